zx_keymatrix: RTL and testbench

ZX_KEYMATRIX -- requirements
Module: zx_keymatrix

---
 rtl/zx_keymatrix_pkg.sv | 109 ++++++++++
 rtl/zx_keymatrix_ps2_rx.sv | 134 +++++++++++++
 rtl/zx_keymatrix.sv | 111 +++++++++++
 tb/tb_zx_keymatrix.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/zx_keymatrix_pkg.sv
// Shared constants, types and the PS/2 set-2 to ZX Spectrum key lookup
// used by the keyboard matrix emulation.
package zx_keymatrix_pkg;

  localparam int ROWS  = 8;
  localparam int COLS  = 5;
  localparam int NCOMP = 5;

  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_BRK = 8'hF0;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  typedef enum logic [2:0] {
    COMP_BKSP,
    COMP_LEFT,
    COMP_DOWN,
    COMP_UP,
    COMP_RIGHT
  } comp_key_e;

  typedef struct packed {
    logic       hit;
    logic       comp;
    comp_key_e  comp_id;
    logic [2:0] row;
    logic [2:0] col;
  } key_map_t;

  // Matrix positions are written as two octal digits: row, then column.
  function automatic key_map_t lookup_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m     = '0;
    m.hit = 1'b1;
    if (ext) begin
      m.comp = 1'b1;
      case (code)
        8'h6B:   m.comp_id = COMP_LEFT;
        8'h72:   m.comp_id = COMP_DOWN;
        8'h75:   m.comp_id = COMP_UP;
        8'h74:   m.comp_id = COMP_RIGHT;
        default: m.hit = 1'b0;
      endcase
    end else begin
      case (code)
        8'h66:        begin m.comp = 1'b1; m.comp_id = COMP_BKSP; end
        8'h12, 8'h59: {m.row, m.col} = 6'o00;
        8'h1A: {m.row, m.col} = 6'o01;
        8'h22: {m.row, m.col} = 6'o02;
        8'h21: {m.row, m.col} = 6'o03;
        8'h2A: {m.row, m.col} = 6'o04;
        8'h1C: {m.row, m.col} = 6'o10;
        8'h1B: {m.row, m.col} = 6'o11;
        8'h23: {m.row, m.col} = 6'o12;
        8'h2B: {m.row, m.col} = 6'o13;
        8'h34: {m.row, m.col} = 6'o14;
        8'h15: {m.row, m.col} = 6'o20;
        8'h1D: {m.row, m.col} = 6'o21;
        8'h24: {m.row, m.col} = 6'o22;
        8'h2D: {m.row, m.col} = 6'o23;
        8'h2C: {m.row, m.col} = 6'o24;
        8'h16: {m.row, m.col} = 6'o30;
        8'h1E: {m.row, m.col} = 6'o31;
        8'h26: {m.row, m.col} = 6'o32;
        8'h25: {m.row, m.col} = 6'o33;
        8'h2E: {m.row, m.col} = 6'o34;
        8'h45: {m.row, m.col} = 6'o40;
        8'h46: {m.row, m.col} = 6'o41;
        8'h3E: {m.row, m.col} = 6'o42;
        8'h3D: {m.row, m.col} = 6'o43;
        8'h36: {m.row, m.col} = 6'o44;
        8'h4D: {m.row, m.col} = 6'o50;
        8'h44: {m.row, m.col} = 6'o51;
        8'h43: {m.row, m.col} = 6'o52;
        8'h3C: {m.row, m.col} = 6'o53;
        8'h35: {m.row, m.col} = 6'o54;
        8'h5A: {m.row, m.col} = 6'o60;
        8'h4B: {m.row, m.col} = 6'o61;
        8'h42: {m.row, m.col} = 6'o62;
        8'h3B: {m.row, m.col} = 6'o63;
        8'h33: {m.row, m.col} = 6'o64;
        8'h29: {m.row, m.col} = 6'o70;
        8'h14: {m.row, m.col} = 6'o71;
        8'h3A: {m.row, m.col} = 6'o72;
        8'h31: {m.row, m.col} = 6'o73;
        8'h32: {m.row, m.col} = 6'o74;
        default: m.hit = 1'b0;
      endcase
    end
    return m;
  endfunction

  // Digit key each composite adds on top of CAPS SHIFT, as {row, col}.
  function automatic logic [5:0] comp_digit(input comp_key_e k);
    case (k)
      COMP_BKSP:  return 6'o40;
      COMP_LEFT:  return 6'o34;
      COMP_DOWN:  return 6'o44;
      COMP_UP:    return 6'o43;
      default:    return 6'o42;
    endcase
  endfunction

endpackage

// File: rtl/zx_keymatrix_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and deglitches the raw lines,
// frames 11-bit words and reports accepted bytes or rejected frames.
module ps2_rx
  import zx_keymatrix_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_err
);

  localparam int FW = $clog2(FILTER + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, clk_sync_d;
  logic [1:0]    dat_sync_q, dat_sync_d;
  logic          filt_q, filt_d;
  logic [FW-1:0] filt_cnt_q, filt_cnt_d;
  logic          fall;
  logic          dat;
  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    byte_q, byte_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;

  assign dat = dat_sync_q[1];

  always_comb begin
    clk_sync_d = {clk_sync_q[0], ps2_clk};
    dat_sync_d = {dat_sync_q[0], ps2_dat};
    filt_d     = filt_q;
    filt_cnt_d = '0;
    fall       = 1'b0;
    // The filtered level flips only after FILTER consecutive disagreeing samples.
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FW'(FILTER - 1)) begin
        filt_d = clk_sync_q[1];
        fall   = filt_q;
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end

    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == RX_IDLE || fall) ? '0 : tmo_q + 1'b1;

    if (fall) begin
      case (state_q)
        RX_IDLE: begin
          if (!dat) begin
            state_d   = RX_DATA;
            bit_cnt_d = '0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = dat;
          state_d  = RX_STOP;
        end
        default: begin
          state_d = RX_IDLE;
          if ((^{shift_q, parity_q}) && dat) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end else if (state_q != RX_IDLE && tmo_q == TW'(TIMEOUT - 1)) begin
      // Abandoned frame: drop it silently.
      state_d   = RX_IDLE;
      shift_d   = '0;
      bit_cnt_d = '0;
      tmo_d     = '0;
    end
  end

  // Synchronizers and filtered level idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      state_q    <= RX_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
      byte_q     <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
      byte_q     <= byte_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
    end
  end

  assign rx_byte  = byte_q;
  assign rx_valid = valid_q;
  assign rx_err   = err_q;

endmodule

// File: rtl/zx_keymatrix.sv
// PS/2 keyboard to ZX Spectrum 8x5 key matrix; the ULA reads key_row by
// pulling address lines A[15:8] low for the half-rows it wants.
module zx_keymatrix
  import zx_keymatrix_pkg::*;
#(
  parameter int FILTER  = 8,
  parameter int TIMEOUT = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  input  logic [7:0] A_hi,
  output logic [4:0] key_row,
  output logic       pressed,
  output logic       rx_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_fail;

  ps2_rx #(
    .FILTER  (FILTER),
    .TIMEOUT (TIMEOUT)
  ) u_rx (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (PS2_CLK),
    .ps2_dat  (PS2_DAT),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_err   (rx_fail)
  );

  logic                       ext_q, ext_d;
  logic                       brk_q, brk_d;
  logic [ROWS-1:0][COLS-1:0]  matrix_q, matrix_d;
  logic [NCOMP-1:0]           comp_q, comp_d;
  logic                       pressed_q, pressed_d;
  key_map_t                   map;

  always_comb begin
    ext_d    = ext_q;
    brk_d    = brk_q;
    matrix_d = matrix_q;
    comp_d   = comp_q;
    map      = lookup_key(ext_q, rx_byte);
    if (rx_fail) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == SC_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == SC_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // Composites live apart so their release never drops a real key.
        if (map.hit) begin
          if (map.comp) comp_d[map.comp_id] = ~brk_q;
          else          matrix_d[map.row][map.col] = ~brk_q;
        end
      end
    end
    pressed_d = (|matrix_d) || (|comp_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      matrix_q  <= '0;
      comp_q    <= '0;
      pressed_q <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      matrix_q  <= matrix_d;
      comp_q    <= comp_d;
      pressed_q <= pressed_d;
    end
  end

  logic [ROWS-1:0][COLS-1:0] eff_row;
  logic [COLS-1:0]           row_or;
  logic [5:0]                pos;

  always_comb begin
    eff_row = matrix_q;
    pos     = '0;
    for (int i = 0; i < NCOMP; i++) begin
      if (comp_q[i]) begin
        pos = comp_digit(comp_key_e'(3'(i)));
        eff_row[0][0] = 1'b1;
        eff_row[pos[5:3]][pos[2:0]] = 1'b1;
      end
    end
    row_or = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!A_hi[r]) row_or = row_or | eff_row[r];
    end
  end

  // Gated by reset so the outputs read idle for the whole reset window.
  assign key_row = reset ? 5'b11111 : ~row_or;
  assign pressed = pressed_q & ~reset;
  assign rx_err  = rx_fail & ~reset;

endmodule

// File: tb/tb_zx_keymatrix.sv
// Directed bench for zx_keymatrix: bit-bangs PS/2 frames and checks the
// half-row readout, pressed flag and error pulse against hand-worked values.
module tb_zx_keymatrix;
  import zx_keymatrix_pkg::*;

  localparam int HALF = 20;
  localparam int TMO  = 1000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] a_hi = 8'hFF;
  logic [4:0] key_row;
  logic       pressed;
  logic       rx_err;

  int n_checks = 0;
  int n_fail = 0;
  int err_cycles = 0;
  int e0;

  zx_keymatrix #(
    .FILTER  (8),
    .TIMEOUT (TMO)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .PS2_CLK (ps2_clk),
    .PS2_DAT (ps2_dat),
    .A_hi    (a_hi),
    .key_row (key_row),
    .pressed (pressed),
    .rx_err  (rx_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  always @(negedge clk) if (rx_err) err_cycles++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    wait_clks(HALF);
    ps2_clk = 1'b0;
    wait_clks(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send(input logic [7:0] code, input logic bad_par);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit((~^code) ^ bad_par);
    ps2_bit(1'b1);
    wait_clks(2 * HALF);
  endtask

  task automatic check_row(input string tag, input logic [7:0] a, input logic [4:0] exp);
    a_hi = a;
    #1;
    check(tag, 32'(key_row), 32'(exp));
  endtask

  initial begin
    wait_clks(5);
    check_row("reset_row", 8'h00, 5'b11111);
    check("reset_pressed", 32'(pressed), 0);
    check("reset_err", 32'(rx_err), 0);
    reset = 1'b0;
    wait_clks(20);
    check("idle_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    check_row("idle_row", 8'h00, 5'b11111);

    send(8'h1C, 1'b0);
    check_row("a_row1", 8'hFD, 5'b11110);
    check_row("a_row0", 8'hFE, 5'b11111);
    check_row("a_none", 8'hFF, 5'b11111);
    check("a_pressed", 32'(pressed), 1);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    check_row("a_rel", 8'hFD, 5'b11111);
    check("a_rel_pressed", 32'(pressed), 0);

    send(8'hE0, 1'b0);
    send(8'h75, 1'b0);
    check_row("up_all", 8'h00, 5'b10110);
    check_row("up_row0", 8'hFE, 5'b11110);
    check_row("up_row4", 8'hEF, 5'b10111);
    send(8'hE0, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h75, 1'b0);
    check_row("up_rel", 8'h00, 5'b11111);
    check("up_rel_pressed", 32'(pressed), 0);

    send(8'h12, 1'b0);
    check_row("shift_row0", 8'hFE, 5'b11110);
    send(8'h66, 1'b0);
    check_row("bksp_row0", 8'hFE, 5'b11110);
    check_row("bksp_row4", 8'hEF, 5'b11110);
    send(8'hF0, 1'b0);
    send(8'h66, 1'b0);
    check_row("bksp_rel_row0", 8'hFE, 5'b11110);
    check_row("bksp_rel_row4", 8'hEF, 5'b11111);
    check("shift_pressed", 32'(pressed), 1);
    send(8'hF0, 1'b0);
    send(8'h12, 1'b0);
    check_row("shift_rel", 8'hFE, 5'b11111);

    e0 = err_cycles;
    send(8'h1C, 1'b1);
    check("bad_err_cycles", 32'(err_cycles - e0), 1);
    check_row("bad_row", 8'hFD, 5'b11111);
    check("bad_pressed", 32'(pressed), 0);
    send(8'h1C, 1'b0);
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    send(8'h22, 1'b0);
    check_row("good_after_bad", 8'hFD, 5'b11110);
    send(8'hF0, 1'b0);
    send(8'h1C, 1'b0);
    check_row("idem_rel", 8'hFD, 5'b11111);

    // A rejected frame must drop a pending E0, so a plain 75 is a miss.
    send(8'hE0, 1'b0);
    send(8'h00, 1'b1);
    send(8'h75, 1'b0);
    check("err_clears_ext", 32'(pressed), 0);
    send(8'hE0, 1'b0);
    send(8'h14, 1'b0);
    check("ext_miss", 32'(pressed), 0);

    e0 = err_cycles;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    check("partial_busy", 32'(dut.u_rx.state_q != RX_IDLE), 1);
    wait_clks(TMO + 500);
    check("tmo_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    check("tmo_no_err", 32'(err_cycles - e0), 0);
    send(8'h29, 1'b0);
    check_row("tmo_space", 8'h7F, 5'b11110);
    send(8'hF0, 1'b0);
    send(8'h29, 1'b0);

    send(8'h1C, 1'b0);
    e0 = err_cycles;
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b0);
    reset = 1'b1;
    check_row("rst_mid_row", 8'hFD, 5'b11111);
    check("rst_mid_pressed", 32'(pressed), 0);
    wait_clks(3);
    reset = 1'b0;
    wait_clks(20);
    check("rst_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    check("rst_no_err", 32'(err_cycles - e0), 0);
    check_row("rst_cleared", 8'hFD, 5'b11111);
    send(8'h29, 1'b0);
    check_row("rst_space", 8'h7F, 5'b11110);
    check("rst_space_pressed", 32'(pressed), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
